mpu_fetch: RTL and testbench

Instruction fetch stage of the MPU. It holds the program counter and drives the 15-bit byte address into the unaligned 8-bank instruction RAM path. It captures the returned 48-bit instruction and hands it to the decoder over a valid/ready handshake. It supports start/stop via en_i, single-cycle jump redirects, and full-throughput (1 instr/cycle) streaming with a one-entry skid buffer to absorb decoder backpressure.

---
 rtl/mpu_fetch_pkg.sv | 17 +
 rtl/mpu_fetch_skid.sv | 94 +++++++++
 rtl/mpu_fetch.sv | 114 +++++++++++
 tb/tb_mpu_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_fetch_pkg.sv
// Shared MPU definitions used by the fetch stage.
//   MPU_ADDR_WIDTH  : byte address width of the instruction space
//   MPU_INSTR_WIDTH : instruction width in bits
//   MPU_INSTR_BYTES : sequential PC step in bytes
//   fetch_state_e   : fetch FSM state encoding
package mpu_fetch_pkg;

    localparam int MPU_ADDR_WIDTH  = 15;
    localparam int MPU_INSTR_WIDTH = 48;
    localparam int MPU_INSTR_BYTES = 6;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/mpu_fetch_skid.sv
// Output register plus one-entry skid buffer for the fetch stage.
// Carries {instr, pc} pairs strictly in arrival order.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   flush_i          : drop output and skid contents (wins over everything)
//   in_valid_i/in_*  : returning instruction and its byte address
//   out_*            : decoder-facing valid/ready interface
//   skid_valid_o     : skid entry occupied (used by the issue rule)
module mpu_fetch_skid #(
    parameter int ADDR_WIDTH  = 15,
    parameter int INSTR_WIDTH = 48
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    input  logic [INSTR_WIDTH-1:0] in_instr_i,
    input  logic [ADDR_WIDTH-1:0]  in_pc_i,
    output logic                   out_valid_o,
    output logic [INSTR_WIDTH-1:0] out_instr_o,
    output logic [ADDR_WIDTH-1:0]  out_pc_o,
    input  logic                   out_ready_i,
    output logic                   skid_valid_o
);

    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q,    out_pc_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0]  skid_pc_q,    skid_pc_d;
    logic                   consume;

    assign consume = out_valid_q & out_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            // New data may bypass into the output only if nothing older waits.
            if (in_valid_i) begin
                if ((!out_valid_q || consume) && !skid_valid_q) begin
                    out_valid_d = 1'b1;
                    out_instr_d = in_instr_i;
                    out_pc_d    = in_pc_i;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = in_instr_i;
                    skid_pc_d    = in_pc_i;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_instr_o  = out_instr_q;
    assign out_pc_o     = out_pc_q;
    assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/mpu_fetch.sv
// MPU instruction fetch stage.
//
//   state      | meaning
//   FETCH_IDLE | stopped; no reads issued, jmp_i ignored
//   FETCH_RUN  | issuing reads of pc, streaming to the decoder
//
// Ports:
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   en_i, start_pc_i          : run enable, PC loaded on leaving IDLE
//   jmp_i, jmp_pc_i           : single-cycle redirect in RUN
//   i_addr_o, i_data_i        : RAM path (data valid one cycle after address)
//   instr_o, instr_pc_o,
//   instr_valid_o, instr_ready_i : decoder handshake
//   busy_o                    : high in RUN
module mpu_fetch
    import mpu_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = MPU_ADDR_WIDTH,
    parameter int INSTR_WIDTH = MPU_INSTR_WIDTH,
    parameter int INSTR_BYTES = MPU_INSTR_BYTES
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   en_i,
    input  logic [ADDR_WIDTH-1:0]  start_pc_i,
    input  logic                   jmp_i,
    input  logic [ADDR_WIDTH-1:0]  jmp_pc_i,
    output logic [ADDR_WIDTH-1:0]  i_addr_o,
    input  logic [INSTR_WIDTH-1:0] i_data_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic                   busy_o
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  flush;
    logic                  issue_ok;
    logic                  skid_valid;

    // Holding back when the output is stalled and a read is already out
    // guarantees output + skid can absorb everything in flight.
    assign issue_ok = !skid_valid && !(instr_valid_o && !instr_ready_i && inflight_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        flush         = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (en_i) begin
                    state_d = FETCH_RUN;
                    pc_d    = start_pc_i;
                end
            end
            FETCH_RUN: begin
                if (!en_i) begin
                    state_d = FETCH_IDLE;
                    flush   = 1'b1;
                end else if (jmp_i) begin
                    pc_d  = jmp_pc_i;
                    flush = 1'b1;
                end else if (issue_ok) begin
                    inflight_d    = 1'b1;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + ADDR_WIDTH'(INSTR_BYTES);
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Data returning in a flush cycle belongs to the old stream and is dropped.
    mpu_fetch_skid #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .flush_i      (flush),
        .in_valid_i   (inflight_q && !flush),
        .in_instr_i   (i_data_i),
        .in_pc_i      (inflight_pc_q),
        .out_valid_o  (instr_valid_o),
        .out_instr_o  (instr_o),
        .out_pc_o     (instr_pc_o),
        .out_ready_i  (instr_ready_i),
        .skid_valid_o (skid_valid)
    );

    assign i_addr_o = pc_q;
    assign busy_o   = (state_q == FETCH_RUN);

endmodule

// File: tb/tb_mpu_fetch.sv
module tb_mpu_fetch;

    logic        sys_clk;
    logic        sys_rst;
    logic        en_i;
    logic [14:0] start_pc_i;
    logic        jmp_i;
    logic [14:0] jmp_pc_i;
    logic [14:0] i_addr_o;
    logic [47:0] i_data_i;
    logic [47:0] instr_o;
    logic [14:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:32767];
    logic [47:0] ram_q;
    logic [14:0] exp_pc;

    mpu_fetch dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .en_i          (en_i),
        .start_pc_i    (start_pc_i),
        .jmp_i         (jmp_i),
        .jmp_pc_i      (jmp_pc_i),
        .i_addr_o      (i_addr_o),
        .i_data_i      (i_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .busy_o        (busy_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Six little-endian bytes starting at a, wrapping at the top of memory.
    function automatic logic [47:0] rd(input logic [14:0] a);
        logic [47:0] r;
        logic [14:0] ai;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            ai = a + 15'(i);
            r[8*i +: 8] = mem[ai];
        end
        return r;
    endfunction

    // RAM: address latched at the edge, data available the following cycle.
    always @(posedge sys_clk) ram_q <= rd(i_addr_o);
    assign i_data_i = ram_q;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; en_i = 1'b0; start_pc_i = '0; jmp_i = 1'b0;
        jmp_pc_i = '0; instr_ready_i = 1'b0;
        cyc(); cyc(); cyc();
        checks++;
        if (instr_valid_o !== 1'b0 || instr_o !== 48'h0 || instr_pc_o !== 15'h0 ||
            i_addr_o !== 15'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: valid=%b instr=%h pc=%h addr=%h busy=%b, expected all zero",
                     instr_valid_o, instr_o, instr_pc_o, i_addr_o, busy_o);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_start();
        cyc();
        en_i = 1'b1; start_pc_i = 15'h0010; instr_ready_i = 1'b1; exp_pc = 15'h0010;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            if (c == 1) begin
                checks++;
                if (i_addr_o !== 15'h0010 || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL start_addr: addr=%h busy=%b, expected 0010 1", i_addr_o, busy_o);
                end
            end
            checks++;
            if (instr_valid_o !== (c >= 3)) begin
                errors++;
                $display("FAIL start_latency: cycle %0d valid=%b expected %b", c, instr_valid_o, c >= 3);
            end
            if (instr_valid_o && instr_ready_i) begin
                checks++;
                if (instr_pc_o !== exp_pc || instr_o !== rd(exp_pc)) begin
                    errors++;
                    $display("FAIL start_stream: pc=%h data=%h expected pc=%h data=%h",
                             instr_pc_o, instr_o, exp_pc, rd(exp_pc));
                end
                exp_pc += 15'd6;
            end
        end
    endtask

    task automatic test_stall();
        logic [14:0] snap_pc, addr1;
        logic [47:0] snap_instr;
        int n;
        snap_pc = '0; addr1 = '0; snap_instr = '0; n = 0;
        for (int s = 0; s < 5; s++) begin
            cyc();
            instr_ready_i = 1'b0;
            if (s == 0) begin
                snap_pc = instr_pc_o; snap_instr = instr_o;
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc) begin
                    errors++;
                    $display("FAIL stall_head: valid=%b pc=%h expected 1 %h", instr_valid_o, instr_pc_o, exp_pc);
                end
            end else begin
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== snap_pc || instr_o !== snap_instr) begin
                    errors++;
                    $display("FAIL stall_frozen: valid=%b pc=%h data=%h expected 1 %h %h",
                             instr_valid_o, instr_pc_o, instr_o, snap_pc, snap_instr);
                end
            end
            if (s == 1) addr1 = i_addr_o;
            if (s == 4) begin
                checks++;
                if (i_addr_o !== addr1) begin
                    errors++;
                    $display("FAIL stall_addr_hold: addr=%h expected %h", i_addr_o, addr1);
                end
            end
        end
        for (int r = 0; r < 10; r++) begin
            cyc();
            instr_ready_i = 1'b1;
            if (instr_valid_o && instr_ready_i) begin
                n++;
                checks++;
                if (instr_pc_o !== exp_pc || instr_o !== rd(exp_pc)) begin
                    errors++;
                    $display("FAIL stall_resume: pc=%h data=%h expected pc=%h data=%h",
                             instr_pc_o, instr_o, exp_pc, rd(exp_pc));
                end
                exp_pc += 15'd6;
            end
        end
        checks++;
        if (n < 7) begin
            errors++;
            $display("FAIL stall_resume_count: transfers=%0d expected at least 7", n);
        end
    endtask

    task automatic test_jump();
        for (int s = 0; s < 2; s++) begin
            cyc();
            instr_ready_i = 1'b0;
        end
        cyc();
        instr_ready_i = 1'b0; jmp_i = 1'b1; jmp_pc_i = 15'h0103; exp_pc = 15'h0103;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            jmp_i = 1'b0; instr_ready_i = 1'b1;
            if (c == 1) begin
                checks++;
                if (i_addr_o !== 15'h0103) begin
                    errors++;
                    $display("FAIL jump_addr: addr=%h expected 0103", i_addr_o);
                end
            end
            if (c <= 3) begin
                checks++;
                if (instr_valid_o !== (c == 3)) begin
                    errors++;
                    $display("FAIL jump_latency: cycle J+%0d valid=%b expected %b", c, instr_valid_o, c == 3);
                end
            end
            if (instr_valid_o && instr_ready_i) begin
                checks++;
                if (instr_pc_o !== exp_pc || instr_o !== rd(exp_pc)) begin
                    errors++;
                    $display("FAIL jump_stream: pc=%h data=%h expected pc=%h data=%h",
                             instr_pc_o, instr_o, exp_pc, rd(exp_pc));
                end
                exp_pc += 15'd6;
            end
        end
    endtask

    task automatic test_wrap();
        logic [14:0] wrap_pcs [3];
        wrap_pcs = '{15'h7FFC, 15'h0002, 15'h0008};
        cyc();
        en_i = 1'b0;
        if (instr_valid_o && instr_ready_i) begin
            checks++;
            if (instr_pc_o !== exp_pc) begin
                errors++;
                $display("FAIL wrap_disable_xfer: pc=%h expected %h", instr_pc_o, exp_pc);
            end
        end
        cyc();
        en_i = 1'b1; start_pc_i = 15'h7FFC; exp_pc = 15'h7FFC;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            if (c >= 3) begin
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== wrap_pcs[c-3] || instr_o !== rd(wrap_pcs[c-3])) begin
                    errors++;
                    $display("FAIL wrap_pc: valid=%b pc=%h data=%h expected 1 %h %h",
                             instr_valid_o, instr_pc_o, instr_o, wrap_pcs[c-3], rd(wrap_pcs[c-3]));
                end
                exp_pc += 15'd6;
            end
        end
    endtask

    task automatic test_disable_jump();
        cyc();
        en_i = 1'b0; jmp_i = 1'b1; jmp_pc_i = 15'h0200;
        if (instr_valid_o && instr_ready_i) begin
            checks++;
            if (instr_pc_o !== exp_pc || instr_o !== rd(exp_pc)) begin
                errors++;
                $display("FAIL disjmp_xfer: pc=%h expected %h", instr_pc_o, exp_pc);
            end
        end
        for (int c = 1; c <= 3; c++) begin
            cyc();
            jmp_i = 1'b0;
            checks++;
            if (busy_o !== 1'b0 || instr_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL disjmp_idle: busy=%b valid=%b expected 0 0", busy_o, instr_valid_o);
            end
        end
        en_i = 1'b1; start_pc_i = 15'h0040; exp_pc = 15'h0040;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 3) begin
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== 15'h0040 || instr_o !== rd(15'h0040)) begin
                    errors++;
                    $display("FAIL reenable_first: valid=%b pc=%h expected 1 0040", instr_valid_o, instr_pc_o);
                end
            end
            if (instr_valid_o && instr_ready_i) exp_pc += 15'd6;
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int s = 0; s < 3; s++) begin
            cyc();
            instr_ready_i = 1'b0;
        end
        cyc();
        sys_rst = 1'b1; en_i = 1'b0;
        cyc();
        sys_rst = 1'b0;
        checks++;
        if (instr_valid_o !== 1'b0 || instr_o !== 48'h0 || instr_pc_o !== 15'h0 ||
            i_addr_o !== 15'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: valid=%b instr=%h pc=%h addr=%h busy=%b, expected all zero",
                     instr_valid_o, instr_o, instr_pc_o, i_addr_o, busy_o);
        end
        instr_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_xfer: valid=%b expected 0", instr_valid_o);
            end
        end
    endtask

    task automatic test_random();
        bit          running, prev_stall;
        logic [14:0] prev_pc;
        logic [47:0] prev_instr;
        int          xfers;
        running = 1'b0; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0; xfers = 0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (prev_stall) begin
                checks++;
                if (instr_valid_o !== 1'b1 || instr_pc_o !== prev_pc || instr_o !== prev_instr) begin
                    errors++;
                    $display("FAIL rand_stall_stable: valid=%b pc=%h expected 1 %h", instr_valid_o, instr_pc_o, prev_pc);
                end
            end
            instr_ready_i = ($urandom_range(0, 3) != 0);
            jmp_i = 1'b0;
            if (!running) begin
                en_i = ($urandom_range(0, 2) == 0);
                start_pc_i = 15'($urandom);
                jmp_i = ($urandom_range(0, 3) == 0);
                jmp_pc_i = 15'($urandom);
                checks++;
                if (instr_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle_valid: valid=%b expected 0", instr_valid_o);
                end
            end else begin
                en_i = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    jmp_i = 1'b1;
                    jmp_pc_i = 15'($urandom);
                end
                if (instr_valid_o && instr_ready_i) begin
                    xfers++;
                    checks++;
                    if (instr_pc_o !== exp_pc || instr_o !== rd(exp_pc)) begin
                        errors++;
                        $display("FAIL rand_stream: pc=%h data=%h expected pc=%h data=%h",
                                 instr_pc_o, instr_o, exp_pc, rd(exp_pc));
                    end
                    exp_pc += 15'd6;
                end
            end
            prev_stall = running && en_i && !jmp_i && instr_valid_o && !instr_ready_i;
            prev_pc    = instr_pc_o;
            prev_instr = instr_o;
            if (!running && en_i) begin
                running = 1'b1;
                exp_pc  = start_pc_i;
            end else if (running && !en_i) begin
                running = 1'b0;
            end else if (running && jmp_i) begin
                exp_pc = jmp_pc_i;
            end
        end
        checks++;
        if (xfers < 200) begin
            errors++;
            $display("FAIL rand_liveness: transfers=%0d expected at least 200", xfers);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        exp_pc = '0;
        test_reset();
        test_start();
        test_stall();
        test_jump();
        test_wrap();
        test_disable_jump();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
